// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

   // Dump engine states
   typedef enum logic [0:0] {
      DUMP_IDLE = 1'b0,
      DUMP_RUN  = 1'b1
   } dump_state_e;

   // Index of the hardwired-zero register: always the topmost entry
   function automatic int unsigned zero_reg_idx(input int unsigned nreg);
      return nreg - 32'd1;
   endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero register, then write bypass, then storage.
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int NREG     = 32,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREG)
) (
   input  logic [AW-1:0]    ra,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [WIDTH-1:0] regs [NREG],
   output logic [WIDTH-1:0] rd
);

   localparam int unsigned ZIDX_I  = zero_reg_idx(NREG);
   localparam logic [AW-1:0] ZIDX  = ZIDX_I[AW-1:0];
   localparam logic       ZERO_EN  = (ZERO_REG != 32'sd0);

   // Select read data: the zero register wins over a same-cycle write to it,
   // and a pending write is forwarded so readers see it without waiting an edge
   always_comb begin
      rd = {WIDTH{1'b0}};
      if (ZERO_EN && (ra == ZIDX)) begin
         rd = {WIDTH{1'b0}};
      end else if (we && (wa == ra)) begin
         rd = wd;
      end else begin
         rd = regs[ra];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with a sequential dump engine.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int NREG     = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [AW-1:0]        wa,
   input  logic [WIDTH-1:0]     wd,
   input  logic [NRD*AW-1:0]    ra,
   output logic [NRD*WIDTH-1:0] rd,
   input  logic                 dump_start,
   output logic                 dump_busy,
   output logic                 dump_valid,
   output logic [AW-1:0]        dump_idx,
   output logic [WIDTH-1:0]     dump_data
);

   localparam int unsigned ZIDX_I  = zero_reg_idx(NREG);
   localparam logic [AW-1:0] ZIDX  = ZIDX_I[AW-1:0];
   localparam int unsigned LAST_I  = NREG - 1;
   localparam logic [AW-1:0] LAST  = LAST_I[AW-1:0];
   localparam logic       ZERO_EN  = (ZERO_REG != 32'sd0);

   // Storage
   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];

   // Dump engine state
   dump_state_e      state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Next storage contents: commit the write unless it targets the zero register
   always_comb begin
      regs_d = regs_q;
      if (we && !(ZERO_EN && (wa == ZIDX))) begin
         regs_d[wa] = wd;
      end else begin
         regs_d = regs_q;
      end
   end

   // Storage flops, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports, one independent instance per port
   for (genvar p = 0; p < NRD; p++) begin : g_rdport
      regfile_rdport #(
         .WIDTH    (WIDTH),
         .NREG     (NREG),
         .ZERO_REG (ZERO_REG)
      ) u_rdport (
         .ra   (ra[p*AW +: AW]),
         .we   (we),
         .wa   (wa),
         .wd   (wd),
         .regs (regs_q),
         .rd   (rd[p*WIDTH +: WIDTH])
      );
   end

   // Dump engine next state: sweep indices 0..NREG-1 from the stored array
   // (no write bypass, so a write on an edge shows up only on later samples)
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      data_d  = data_q;
      case (state_q)
         DUMP_IDLE: begin
            valid_d = 1'b0;
            if (dump_start) begin
               state_d = DUMP_RUN;
               cnt_d   = {AW{1'b0}};
            end else begin
               state_d = DUMP_IDLE;
            end
         end
         DUMP_RUN: begin
            valid_d = 1'b1;
            idx_d   = cnt_q;
            if (ZERO_EN && (cnt_q == ZIDX)) begin
               data_d = {WIDTH{1'b0}};
            end else begin
               data_d = regs_q[cnt_q];
            end
            if (cnt_q == LAST) begin
               state_d = DUMP_IDLE;
               cnt_d   = {AW{1'b0}};
            end else begin
               state_d = DUMP_RUN;
               cnt_d   = cnt_q + AW'(1'b1);
            end
         end
         default: begin
            state_d = DUMP_IDLE;
            cnt_d   = {AW{1'b0}};
            valid_d = 1'b0;
         end
      endcase
   end

   // Dump engine flops; outputs come straight from registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DUMP_IDLE;
         cnt_q   <= {AW{1'b0}};
         valid_q <= 1'b0;
         idx_q   <= {AW{1'b0}};
         data_q  <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   assign dump_busy  = (state_q == DUMP_RUN);
   assign dump_valid = valid_q;
   assign dump_idx   = idx_q;
   assign dump_data  = data_q;

endmodule
